// File: rtl/rev_wrap_tracker.sv
// Extends a 16-bit reversible counter with a signed 8-bit wrap count and a
// level interrupt handshake (IDLE/PEND/ACKD) that reports each wrap to a consumer.
module rev_wrap_tracker (
  input  logic        clk,
  input  logic        rst,
  input  logic        s,
  input  logic [15:0] cnt,
  input  logic        Rc,
  input  logic        ack,
  input  logic        clr,
  output logic [7:0]  wraps,
  output logic        ovf,
  output logic        irq,
  output logic        last_dir,
  output logic [3:0]  missed
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACKD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  wraps_q, wraps_d;
  logic        ovf_q, ovf_d;
  logic        irq_q, irq_d;
  logic        last_dir_q, last_dir_d;
  logic [3:0]  missed_q, missed_d;
  logic        wrap_ev;

  // cnt forms the low word of the position outside this block; wraps are
  // detected from the terminal-count flag alone.
  logic cnt_unused;
  assign cnt_unused = ^cnt;

  // A clear discards a coincident wrap completely, including its FSM effect.
  assign wrap_ev = Rc & ~clr;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    wraps_d    = wraps_q;
    ovf_d      = ovf_q;
    last_dir_d = last_dir_q;
    missed_d   = missed_q;

    unique case (state_q)
      IDLE:    if (wrap_ev) state_d = PEND;
      PEND:    if (ack)     state_d = ACKD;
      ACKD:    if (!ack)    state_d = IDLE;
      default:              state_d = IDLE;
    endcase

    if (wrap_ev) begin
      last_dir_d = s;
      if (s) begin
        wraps_d = wraps_q + 8'd1;
        if (wraps_q == 8'h7F) ovf_d = 1'b1;
      end else begin
        wraps_d = wraps_q - 8'd1;
        if (wraps_q == 8'h80) ovf_d = 1'b1;
      end
      if (state_q != IDLE && missed_q != 4'hF) missed_d = missed_q + 4'd1;
    end

    if (clr) begin
      wraps_d  = 8'h00;
      ovf_d    = 1'b0;
      missed_d = 4'h0;
    end

    // irq is registered from the next state so the output has no decode logic.
    irq_d = (state_d == PEND);
  end

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous
  // so irq drops the moment rst rises, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wraps_q    <= 8'h00;
      ovf_q      <= 1'b0;
      irq_q      <= 1'b0;
      last_dir_q <= 1'b0;
      missed_q   <= 4'h0;
    end else begin
      state_q    <= state_d;
      wraps_q    <= wraps_d;
      ovf_q      <= ovf_d;
      irq_q      <= irq_d;
      last_dir_q <= last_dir_d;
      missed_q   <= missed_d;
    end
  end

  assign wraps    = wraps_q;
  assign ovf      = ovf_q;
  assign irq      = irq_q;
  assign last_dir = last_dir_q;
  assign missed   = missed_q;

endmodule

// File: tb/tb_rev_wrap_tracker.sv
// Self-checking bench for rev_wrap_tracker: directed vector table, hand-written
// corner sequences, then random stimulus against a behavioural model.
module tb_rev_wrap_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s   = 1'b0;
  logic [15:0] cnt = 16'h0000;
  logic        Rc  = 1'b0;
  logic        ack = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  wraps;
  logic        ovf;
  logic        irq;
  logic        last_dir;
  logic [3:0]  missed;

  int total = 0;
  int bad   = 0;

  rev_wrap_tracker dut (
    .clk(clk), .rst(rst), .s(s), .cnt(cnt), .Rc(Rc), .ack(ack), .clr(clr),
    .wraps(wraps), .ovf(ovf), .irq(irq), .last_dir(last_dir), .missed(missed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s, rc, ack, clr;
    logic [7:0] e_wraps;
    logic       e_ovf, e_irq, e_dir;
    logic [3:0] e_missed;
  } vec_t;

  // Behavioural model: net wrap count as an integer, handshake as two flags.
  int  m_net;
  bit  m_ovf, m_dir, m_waiting_ack, m_waiting_release;
  int  m_missed;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] w, input logic o,
                           input logic i, input logic d, input logic [3:0] m);
    check({tag, ".wraps"},    {8'h0, wraps},    {8'h0, w});
    check({tag, ".ovf"},      {15'h0, ovf},     {15'h0, o});
    check({tag, ".irq"},      {15'h0, irq},     {15'h0, i});
    check({tag, ".last_dir"}, {15'h0, last_dir}, {15'h0, d});
    check({tag, ".missed"},   {12'h0, missed},  {12'h0, m});
  endtask

  task automatic model_reset();
    m_net = 0; m_ovf = 0; m_dir = 0; m_waiting_ack = 0; m_waiting_release = 0; m_missed = 0;
  endtask

  task automatic model_step(input logic ms, input logic mrc, input logic mack, input logic mclr);
    bit busy;
    bit wrap;
    wrap = mrc && !mclr;
    busy = m_waiting_ack || m_waiting_release;
    if (wrap) begin
      m_dir = ms;
      if (ms && m_net == 127)   m_ovf = 1;
      if (!ms && m_net == -128) m_ovf = 1;
      m_net = ms ? m_net + 1 : m_net - 1;
      if (m_net > 127)  m_net -= 256;
      if (m_net < -128) m_net += 256;
      if (busy && m_missed < 15) m_missed++;
    end
    if (m_waiting_ack) begin
      if (mack) begin m_waiting_ack = 0; m_waiting_release = 1; end
    end else if (m_waiting_release) begin
      if (!mack) m_waiting_release = 0;
    end else if (wrap) begin
      m_waiting_ack = 1;
    end
    if (mclr) begin m_net = 0; m_ovf = 0; m_missed = 0; end
  endtask

  task automatic model_check(input string tag);
    logic [7:0] w;
    w = 8'(m_net);
    check_all(tag, w, m_ovf, m_waiting_ack, m_dir, 4'(m_missed));
  endtask

  // One clock: inputs held across the edge, outputs sampled 1 ns after it.
  task automatic step(input logic ts, input logic trc, input logic tack, input logic tclr);
    s = ts; Rc = trc; ack = tack; clr = tclr;
    cnt = trc ? (ts ? 16'hFFFF : 16'h0000) : 16'h1234;
    @(posedge clk);
    #1;
    model_step(ts, trc, tack, tclr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; Rc = 0; ack = 0; clr = 0;
    #2;
    check_all("rst_async", 8'h00, 0, 0, 0, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  vec_t vt[13];

  initial begin
    // s rc ack clr | wraps ovf irq dir missed
    vt[0]  = '{1,1,0,0, 8'h01,0,1,1,4'h0};
    vt[1]  = '{1,0,1,0, 8'h01,0,0,1,4'h0};
    vt[2]  = '{1,0,1,0, 8'h01,0,0,1,4'h0};
    vt[3]  = '{1,0,0,0, 8'h01,0,0,1,4'h0};
    vt[4]  = '{0,1,0,0, 8'h00,0,1,0,4'h0};
    vt[5]  = '{0,1,0,0, 8'hFF,0,1,0,4'h1};
    vt[6]  = '{1,1,1,0, 8'h00,0,0,1,4'h2};
    vt[7]  = '{1,1,0,0, 8'h01,0,0,1,4'h3};
    vt[8]  = '{1,0,0,0, 8'h01,0,0,1,4'h3};
    vt[9]  = '{0,1,0,1, 8'h00,0,0,1,4'h0};
    vt[10] = '{0,1,0,0, 8'hFF,0,1,0,4'h0};
    vt[11] = '{0,0,1,1, 8'h00,0,0,0,4'h0};
    vt[12] = '{0,0,0,0, 8'h00,0,0,0,4'h0};

    do_reset();
    check_all("reset", 8'h00, 0, 0, 0, 4'h0);

    for (int i = 0; i < 13; i++) begin
      step(vt[i].s, vt[i].rc, vt[i].ack, vt[i].clr);
      check_all($sformatf("vec%0d", i), vt[i].e_wraps, vt[i].e_ovf, vt[i].e_irq,
                vt[i].e_dir, vt[i].e_missed);
    end

    // Down-wrap straight out of reset, taken on the first edge.
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    s = 0; Rc = 1; cnt = 16'h0000;
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    model_step(0, 1, 0, 0);
    check_all("down_first_edge", 8'hFF, 0, 1, 0, 4'h0);

    // Overflow: 127 up-wraps stay in range, the 128th sets ovf.
    do_reset();
    for (int i = 0; i < 127; i++) step(1, 1, 0, 0);
    check_all("up127", 8'h7F, 0, 1, 1, 4'hF);
    step(1, 1, 0, 0);
    check_all("up128", 8'h80, 1, 1, 1, 4'hF);
    step(0, 1, 0, 0);
    check_all("ovf_sticky", 8'h7F, 1, 1, 0, 4'hF);
    step(0, 0, 0, 1);
    check_all("clr_ovf", 8'h00, 0, 1, 0, 4'h0);

    // Missed saturation: one raising wrap plus 20 unacknowledged ones.
    do_reset();
    for (int i = 0; i < 21; i++) step(1, 1, 0, 0);
    check_all("missed_sat", 8'h15, 0, 1, 1, 4'hF);

    // Asynchronous reset while PEND drops irq without a clock edge.
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_pend.irq", {15'h0, irq}, 16'h0);
    check("rst_pend.wraps", {8'h0, wraps}, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1, 0, 1, 0);
    check_all("ack_ignored", 8'h00, 0, 0, 0, 4'h0);
    step(1, 1, 0, 0);
    check_all("wrap_after_rst", 8'h01, 0, 1, 1, 4'h0);

    // Random stimulus against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic rs, rrc, rack, rclr;
      rs   = 1'($urandom_range(0, 1));
      rrc  = ($urandom_range(0, 99) < 40);
      rack = ($urandom_range(0, 99) < 35);
      rclr = ($urandom_range(0, 99) < 3);
      if (i >= 1000 && i < 1600) begin rs = 1; rrc = 1; rclr = 0; end
      step(rs, rrc, rack, rclr);
      model_check($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rev_wrap_tracker.md
REV_WRAP_TRACKER -- requirements
Module: rev_wrap_tracker

Interface
REQ-001 The block SHALL run on one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge system clock, shared with the upstream 16-bit reversible counter.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 s  input  1  count direction of the upstream counter: 1 = up, 0 = down.
REQ-005 cnt  input  16  current upstream count value.
REQ-006 Rc  input  1  upstream terminal-count flag: high when s=1 with cnt=16'hFFFF, or s=0 with cnt=16'h0000.
REQ-007 ack  input  1  interrupt acknowledge from the consumer (level).
REQ-008 clr  input  1  synchronous clear of the tracking state.
REQ-009 wraps  output  8  two's-complement net wrap count, forming the upper word of position {wraps, cnt}.
REQ-010 ovf  output  1  sticky wrap-count overflow flag.
REQ-011 irq  output  1  wrap interrupt request (level).
REQ-012 last_dir  output  1  direction of the most recent counted wrap: 1 = up, 0 = down.
REQ-013 missed  output  4  saturating count of wraps that occurred while an interrupt was outstanding.

Function
REQ-014 A wrap event SHALL be Rc=1 sampled at a rising clk edge; the upstream counter wraps on that same edge.
REQ-015 On a wrap event with s=1, wraps SHALL increment by 1; with s=0, it SHALL decrement by 1. The update is visible in the cycle after the edge, consistent with the wrapped cnt.
REQ-016 wraps SHALL wrap modulo 256. An up-wrap at 8'h7F or a down-wrap at 8'h80 SHALL set ovf, which stays set until clr or rst.
REQ-017 last_dir SHALL load s on every wrap event.
REQ-018 The FSM SHALL have three states: IDLE, PEND and ACKD; irq=1 only in PEND.
REQ-019 IDLE -> PEND on a wrap event.
REQ-020 PEND -> ACKD when ack=1 is sampled; irq falls in the next cycle.
REQ-021 ACKD -> IDLE when ack=0 is sampled. ACKD is held while ack stays high.
REQ-022 A wrap event in PEND or ACKD SHALL still update wraps, ovf and last_dir. It SHALL increment missed, saturating at 4'hF, and SHALL NOT change the FSM state.
REQ-023 A wrap event in PEND with ack=1 on the same edge SHALL move the FSM to ACKD and increment missed.
REQ-024 A wrap event on the edge where ACKD -> IDLE SHALL NOT raise irq; it counts as missed.
REQ-025 clr=1 SHALL set wraps=0, ovf=0 and missed=0 at the edge, and SHALL discard a coincident wrap event entirely. The FSM state and last_dir are unaffected by clr.
REQ-026 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-027 Rc=1 held over consecutive edges (counter parked at terminal count and direction unchanged) SHALL count one wrap per edge, matching the upstream behaviour.

Reset
REQ-028 rst=1 SHALL immediately force wraps=8'h00, ovf=0, irq=0, last_dir=0, missed=4'h0 and FSM=IDLE, independent of clk.
REQ-029 rst asserted mid-handshake (PEND or ACKD) SHALL drop irq at once. After rst deasserts, the block SHALL resume in IDLE with ack ignored until the next wrap event.
REQ-030 The first rising edge after rst deasserts SHALL be processed normally, including a wrap event on that edge.

Verification
REQ-031 Up-wrap: cnt=16'hFFFF, s=1, Rc=1 for one edge -> wraps=8'h01, last_dir=1, irq=1 in the next cycle; ack=1 -> irq=0 one cycle later; ack=0 -> IDLE.
REQ-032 Down-wrap from reset: cnt=16'h0000, s=0, Rc=1 for one edge -> wraps=8'hFF, last_dir=0, irq=1.
REQ-033 Overflow: 127 up-wraps then one more -> wraps=8'h80 and ovf=1; ovf is still 1 after a subsequent down-wrap; clr -> wraps=0, ovf=0.
REQ-034 Missed events: raise irq, withhold ack for 20 up-wraps -> missed=4'hF, wraps=8'h15, irq stays 1.
REQ-035 clr coincident with a wrap event in IDLE -> wraps=0 and irq stays 0; rst pulsed in PEND -> irq=0 with no clock edge.
